mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: funct3 access sizes, FSM states,
// the latched request bundle and the access-legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } req_t;

  // Unsigned sizes exist only for loads; a store carrying them is illegal.
  function automatic logic access_error(input req_t r, input logic [32:0] limit_bytes);
    logic illegal;
    logic misaligned;
    case (r.funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = r.write;
      default:          illegal = 1'b1;
    endcase
    misaligned = ((r.funct3[1:0] == 2'b01) && r.addr[0]) ||
                 ((r.funct3[1:0] == 2'b10) && (r.addr[1:0] != 2'b00));
    return illegal || misaligned || ({1'b0, r.addr} >= limit_bytes);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load byte/half select with sign or zero
// extension, and store lane shift with matching byte enables.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] wr_word_o,
  output logic [3:0]  wr_be_o
);

  logic [31:0] shifted;

  assign shifted   = rd_word_i >> {byte_off_i, 3'b000};
  assign wr_word_o = wdata_i << {byte_off_i, 3'b000};

  always_comb begin
    load_data_o = 32'd0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = rd_word_i;
      F3_BU:   load_data_o = {24'd0, shifted[7:0]};
      F3_HU:   load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = 32'd0;
    endcase
  end

  always_comb begin
    wr_be_o = 4'b0000;
    case (funct3_i[1:0])
      2'b00:   wr_be_o = 4'b0001 << byte_off_i;
      2'b01:   wr_be_o = 4'b0011 << byte_off_i;
      2'b10:   wr_be_o = 4'b1111;
      default: wr_be_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request in IDLE, waits
// WAIT_CYCLES, commits stores on entry to RESPOND and returns a registered response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_LOAD    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_q;

  req_t             cur_req;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      load_data;
  logic [31:0]      wr_word;
  logic [3:0]       wr_be;
  logic             wr_en;

  // In IDLE the incoming request is the live one, so a zero-wait accept can
  // address storage on the same edge it is latched.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_req.write  = req_write;
      cur_req.addr   = req_addr;
      cur_req.funct3 = req_funct3;
      cur_req.wdata  = req_wdata;
    end else begin
      cur_req = req_q;
    end
  end

  assign cur_err = access_error(cur_req, LIMIT_BYTES);
  assign cur_idx = cur_req.addr[IDX_W+1:2];

  mem_lane_align u_align (
    .funct3_i    (cur_req.funct3),
    .byte_off_i  (cur_req.addr[1:0]),
    .rd_word_i   (rd_word_q),
    .wdata_i     (cur_req.wdata),
    .load_data_o (load_data),
    .wr_word_o   (wr_word),
    .wr_be_o     (wr_be)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = cur_req;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESPOND: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = cur_err;
        rsp_rdata_d = (cur_err || req_q.write) ? 32'd0 : load_data;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Gating on reset keeps a request presented during reset from writing.
  assign wr_en = (state_q != ST_RESPOND) && (state_d == ST_RESPOND) &&
                 cur_req.write && !cur_err && !reset;

  always_ff @(posedge clk) begin
    rd_word_q <= mem[cur_idx];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[cur_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder: two instances (1 and 3 wait
// states) compared against a byte-array reference model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_error  [2];

  int checks = 0;
  int errors = 0;

  byte unsigned ref_mem [2][4096];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0])
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1])
  );

  function automatic int wc(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit exp_error(input bit w, input logic [31:0] a, input logic [2:0] f3);
    bit legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!w && ((f3 == 3'd4) || (f3 == 3'd5)));
    return !legal || ((a % acc_size(f3)) != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] exp_load(input int u, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = acc_size(f3);
    v = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[u][a + 32'(i)]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input int u, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < acc_size(f3); i++) ref_mem[u][a + 32'(i)] = 8'(wd >> (8 * i));
  endtask

  task automatic do_req(input int u, input bit w, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input string tag, output logic [31:0] obs);
    int k;
    bit e;
    logic [31:0] exp_r;
    k = 0;
    while (req_ready[u] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, ":ready_idle"}, {31'd0, req_ready[u]}, 32'd1);
    e = exp_error(w, a, f3);
    exp_r = (e || w) ? 32'd0 : exp_load(u, a, f3);
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a;
    req_funct3[u] = f3;  req_wdata[u] = wd;
    @(negedge clk);
    req_valid[u] = 1'b0; req_addr[u] = $urandom(); req_wdata[u] = $urandom();
    req_funct3[u] = 3'($urandom_range(0, 7));
    check({tag, ":ready_busy"}, {31'd0, req_ready[u]}, 32'd0);
    k = 0;
    while (rsp_valid[u] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, ":latency"}, 32'(k), 32'(wc(u) + 1));
    check({tag, ":error"}, {31'd0, rsp_error[u]}, {31'd0, e});
    check({tag, ":rdata"}, rsp_rdata[u], exp_r);
    obs = rsp_rdata[u];
    if (w && !e) model_store(u, a, f3, wd);
    $display("txn %s u=%0d w=%0d addr=%h f3=%0d wdata=%h rdata=%h err=%0d lat=%0d",
             tag, u, w, a, f3, wd, rsp_rdata[u], rsp_error[u], k);
    @(negedge clk);
    check({tag, ":pulse"}, {31'd0, rsp_valid[u]}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs;
    logic [2:0]  f3_tab [13] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1,
                                 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    int acc[$];
    int not_ready;
    int pulses;

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_write[u] = 1'b0;
      req_addr[u] = 32'd0; req_funct3[u] = 3'd0; req_wdata[u] = 32'd0;
    end
    repeat (3) @(negedge clk);
    check("reset:ready", {31'd0, req_ready[0]}, 32'd1);
    check("reset:rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("reset:rdata", rsp_rdata[0], 32'd0);
    check("reset:error", {31'd0, rsp_error[0]}, 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Directed word/byte/half cases on the one-wait-state instance.
    do_req(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "sw_10", obs);
    do_req(0, 1'b0, 32'h10, 3'd2, 32'h0, "lw_10", obs);
    check("lw_10:const", obs, 32'hDEADBEEF);
    do_req(0, 1'b1, 32'h13, 3'd0, 32'h12345680, "sb_13", obs);
    do_req(0, 1'b0, 32'h13, 3'd0, 32'h0, "lb_13", obs);
    check("lb_13:const", obs, 32'hFFFFFF80);
    do_req(0, 1'b0, 32'h13, 3'd4, 32'h0, "lbu_13", obs);
    check("lbu_13:const", obs, 32'h00000080);
    do_req(0, 1'b0, 32'h10, 3'd2, 32'h0, "lw_10b", obs);
    check("lw_10b:const", obs, 32'h80ADBEEF);
    do_req(0, 1'b0, 32'h12, 3'd2, 32'h0, "lw_mis", obs);
    do_req(0, 1'b1, 32'h11, 3'd1, 32'hFFFF, "sh_mis", obs);
    do_req(0, 1'b0, 32'h1000, 3'd2, 32'h0, "lw_oor", obs);
    do_req(0, 1'b1, 32'h10, 3'd4, 32'hFFFFFFFF, "st_f3_4", obs);
    do_req(0, 1'b0, 32'h10, 3'd2, 32'h0, "lw_10c", obs);
    check("lw_10c:const", obs, 32'h80ADBEEF);

    // Busy: hold req_valid and measure accept spacing.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_funct3[0] = 3'd2;
    not_ready = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready[0] === 1'b1) acc.push_back(i);
      else not_ready++;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("busy:accepts", 32'(acc.size()), 32'd4);
    check("busy:not_ready", 32'(not_ready), 32'd8);
    for (int j = 1; j < acc.size(); j++)
      check("busy:spacing", 32'(acc[j] - acc[j-1]), 32'(wc(0) + 2));
    $display("txn busy accepts=%0d not_ready=%0d", acc.size(), not_ready);

    // Random traffic over a fully initialised 64-byte window.
    for (int i = 0; i < 16; i++)
      do_req(0, 1'b1, 32'(i * 4), 3'd2, $urandom(), "init", obs);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 15)) * 4)
                                      : 32'($urandom_range(0, 63));
      do_req(0, 1'($urandom_range(0, 1)), a, f3_tab[$urandom_range(0, 12)],
             $urandom(), "rand", obs);
    end

    // Reset during WAIT on the three-wait-state instance drops the store.
    do_req(1, 1'b1, 32'h20, 3'd2, 32'h11223344, "w3_sw", obs);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20;
    req_funct3[1] = 3'd2; req_wdata[1] = 32'hAAAA5555;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("w3_rst:in_wait", {31'd0, req_ready[1]}, 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    check("w3_rst:ready", {31'd0, req_ready[1]}, 32'd1);
    rst[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[1] === 1'b1) pulses++;
      @(negedge clk);
    end
    check("w3_rst:no_rsp", 32'(pulses), 32'd0);
    do_req(1, 1'b0, 32'h20, 3'd2, 32'h0, "w3_lw", obs);
    check("w3_lw:const", obs, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
